// File: rtl/pwm_fade_sequencer.sv
// pwm_fade_sequencer
// Sequences a breathing fade (ramp up, hold at peak, ramp down) across NCH
// PWM channels, one channel at a time, round-robin.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   en         clock enable; low freezes all state and outputs
//   start      one-cycle request to begin sequencing (ignored while busy)
//   stop       one-cycle request to stop after the current channel's fade
//   pwm_out    registered PWM outputs, only the active channel's bit may be high
//   active_ch  index of the channel being faded
//   duty       current duty of the active channel (clocks high per period)
//   busy       high whenever the sequencer is not idle
//   round_done one-cycle pulse when channel NCH-1 completes its fade
module pwm_fade_sequencer #(
  parameter int NCH      = 4,
  parameter int DW       = 5,
  parameter int MAX_DUTY = 16,
  parameter int PERIOD   = 32,
  parameter int HOLD     = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     start,
  input  logic                     stop,
  output logic [NCH-1:0]           pwm_out,
  output logic [$clog2(NCH)-1:0]   active_ch,
  output logic [DW-1:0]            duty,
  output logic                     busy,
  output logic                     round_done
);

  localparam int CW = $clog2(PERIOD);
  localparam int HW = $clog2(HOLD + 1);
  localparam int AW = $clog2(NCH);

  typedef enum logic [1:0] {S_IDLE, S_UP, S_HOLD, S_DOWN} state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   duty_q, duty_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [AW-1:0]   ach_q, ach_d;
  logic            pend_q, pend_d;
  logic [NCH-1:0]  pwm_q, pwm_d;
  logic            rd_q, rd_d;
  logic            tick;

  assign tick = (cnt_q == CW'(PERIOD - 1)) && en;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    duty_d  = duty_q;
    hold_d  = hold_q;
    ach_d   = ach_q;
    pend_d  = pend_q;
    pwm_d   = '0;
    rd_d    = 1'b0;
    if (state_q == S_IDLE) begin
      cnt_d = '0;
      // start takes priority; a coincident stop is simply dropped
      if (start) begin
        state_d = S_UP;
        duty_d  = '0;
        ach_d   = '0;
        pend_d  = 1'b0;
      end
    end else begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
      pwm_d[ach_q] = (32'(cnt_q) < 32'(duty_q));
      if (stop) pend_d = 1'b1;
      // duty/state/channel move only at period boundaries so no period is cut short
      if (tick) begin
        case (state_q)
          S_UP: begin
            duty_d = duty_q + DW'(1);
            if (duty_q == DW'(MAX_DUTY - 1)) begin
              state_d = S_HOLD;
              hold_d  = '0;
            end
          end
          S_HOLD: begin
            hold_d = hold_q + HW'(1);
            if (hold_q == HW'(HOLD - 1)) state_d = S_DOWN;
          end
          S_DOWN: begin
            duty_d = duty_q - DW'(1);
            if (duty_q == DW'(1)) begin
              ach_d = (ach_q == AW'(NCH - 1)) ? '0 : ach_q + AW'(1);
              rd_d  = (ach_q == AW'(NCH - 1));
              if (pend_q || stop) begin
                state_d = S_IDLE;
                pend_d  = 1'b0;
              end else begin
                state_d = S_UP;
                duty_d  = '0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      duty_q  <= '0;
      hold_q  <= '0;
      ach_q   <= '0;
      pend_q  <= 1'b0;
      pwm_q   <= '0;
      rd_q    <= 1'b0;
    end else if (en) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      duty_q  <= duty_d;
      hold_q  <= hold_d;
      ach_q   <= ach_d;
      pend_q  <= pend_d;
      pwm_q   <= pwm_d;
      rd_q    <= rd_d;
    end
  end

  assign pwm_out    = pwm_q;
  assign active_ch  = ach_q;
  assign duty       = duty_q;
  assign busy       = (state_q != S_IDLE);
  assign round_done = rd_q;

endmodule

// File: tb/tb_pwm_fade_sequencer.sv
module tb_pwm_fade_sequencer;

  logic clk = 1'b0;
  logic rst, en, start, stop;

  logic [3:0] pwm0, pwm1;
  logic [1:0] ach0, ach1;
  logic [4:0] duty0;
  logic [3:0] duty1;
  logic       busy0, busy1, rd0, rd1;

  always #5 clk = ~clk;

  pwm_fade_sequencer #(.NCH(4), .DW(5), .MAX_DUTY(16), .PERIOD(32), .HOLD(2)) u_dut (
    .clk(clk), .rst(rst), .en(en), .start(start), .stop(stop),
    .pwm_out(pwm0), .active_ch(ach0), .duty(duty0), .busy(busy0), .round_done(rd0)
  );

  // full-duty corner: MAX_DUTY == PERIOD
  pwm_fade_sequencer #(.NCH(4), .DW(4), .MAX_DUTY(8), .PERIOD(8), .HOLD(1)) u_dut8 (
    .clk(clk), .rst(rst), .en(en), .start(start), .stop(stop),
    .pwm_out(pwm1), .active_ch(ach1), .duty(duty1), .busy(busy1), .round_done(rd1)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: each fade is a timeline of 2*MAX+HOLD periods; duty is
  // a function of the period index inside that timeline.
  localparam int PER [2] = '{32, 8};
  localparam int MXD [2] = '{16, 8};
  localparam int HLD [2] = '{2, 1};

  int m_run [2] = '{0, 0};
  int m_ch  [2] = '{0, 0};
  int m_p   [2] = '{0, 0};
  int m_pend[2] = '{0, 0};
  int m_pwm [2] = '{0, 0};
  int m_rd  [2] = '{0, 0};

  function automatic int dutyf(int i, int k);
    if (k < MXD[i]) return k;
    if (k < MXD[i] + HLD[i]) return MXD[i];
    return 2 * MXD[i] + HLD[i] - k;
  endfunction

  function automatic int exp_duty(int i);
    return (m_run[i] != 0) ? dutyf(i, m_p[i] / PER[i]) : 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        m_run[i] = 0; m_ch[i] = 0; m_p[i] = 0; m_pend[i] = 0; m_pwm[i] = 0; m_rd[i] = 0;
      end
    end else if (en) begin
      for (int i = 0; i < 2; i++) begin
        if (m_run[i] == 0) begin
          m_pwm[i] = 0;
          m_rd[i]  = 0;
          if (start) begin
            m_run[i] = 1; m_ch[i] = 0; m_p[i] = 0; m_pend[i] = 0;
          end
        end else begin
          m_pwm[i] = ((m_p[i] % PER[i]) < dutyf(i, m_p[i] / PER[i])) ? (1 << m_ch[i]) : 0;
          m_rd[i]  = 0;
          if (stop) m_pend[i] = 1;
          m_p[i]++;
          if (m_p[i] == (2 * MXD[i] + HLD[i]) * PER[i]) begin
            m_rd[i] = (m_ch[i] == 3) ? 1 : 0;
            m_ch[i] = (m_ch[i] + 1) % 4;
            m_p[i]  = 0;
            if (m_pend[i] != 0) begin
              m_run[i] = 0; m_pend[i] = 0;
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      chk("pwm0",   int'(pwm0),  m_pwm[0]);
      chk("duty0",  int'(duty0), exp_duty(0));
      chk("ach0",   int'(ach0),  m_ch[0]);
      chk("busy0",  int'(busy0), m_run[0]);
      chk("rd0",    int'(rd0),   m_rd[0]);
      chk("onehot0", ($countones(pwm0) <= 1) ? 1 : 0, 1);
      chk("pwm1",   int'(pwm1),  m_pwm[1]);
      chk("duty1",  int'(duty1), exp_duty(1));
      chk("ach1",   int'(ach1),  m_ch[1]);
      chk("busy1",  int'(busy1), m_run[1]);
      chk("rd1",    int'(rd1),   m_rd[1]);
    end
  end

  int hc [34];
  int h8, nrd, rd_s;

  initial begin
    rst = 1'b1; en = 1'b1; start = 1'b0; stop = 1'b0;
    for (int i = 0; i < 34; i++) hc[i] = 0;
    h8 = 0; nrd = 0; rd_s = -1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // idle after reset
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (i == 0 || i == 99) begin
        chk("idle_busy", int'(busy0), 0);
        chk("idle_pwm",  int'(pwm0),  0);
        chk("idle_duty", int'(duty0), 0);
        chk("idle_ach",  int'(ach0),  0);
      end
    end

    // single fade, full round, stop during HOLD of channel 2
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", int'(busy0), 1);
    for (int s = 1; s <= 7620; s++) begin
      @(negedge clk);
      start = (s == 500);
      stop  = (s == 7050);
      if (s <= 1088) hc[(s - 1) / 32] += int'(pwm0[0]);
      if (s >= 65 && s <= 72) h8 += int'(pwm1[0]);
      if (s <= 5000 && rd0) begin nrd++; rd_s = s; end
      if (s == 73) chk("full_duty_hold", h8, 8);
      if (s == 1087) chk("ach_before_handover", int'(ach0), 0);
      if (s == 1088) begin
        chk("ach_after_handover", int'(ach0), 1);
        chk("hc_p0",  hc[0],  0);
        chk("hc_p1",  hc[1],  1);
        chk("hc_p16", hc[16], 16);
        chk("hc_p17", hc[17], 16);
        chk("hc_p33", hc[33], 1);
      end
      if (s == 4352) chk("ach_wrap", int'(ach0), 0);
      if (s == 5000) begin
        chk("round_done_count", nrd, 1);
        chk("round_done_time", rd_s, 4352);
      end
      if (s == 7615) begin
        chk("stop_still_busy", int'(busy0), 1);
        chk("stop_ach_2", int'(ach0), 2);
      end
      if (s == 7616) begin
        chk("stop_idle", int'(busy0), 0);
        chk("stop_ach_3", int'(ach0), 3);
        chk("stop_pwm", int'(pwm0), 0);
      end
    end
    start = 1'b0; stop = 1'b0;

    // restart begins at channel 0
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("restart_busy", int'(busy0), 1);
    chk("restart_ach", int'(ach0), 0);

    // enable freeze at cnt=10, duty=8
    for (int s = 1; s <= 266; s++) @(negedge clk);
    chk("pre_freeze_duty", int'(duty0), 8);
    en = 1'b0;
    repeat (50) @(negedge clk);
    chk("freeze_duty", int'(duty0), 8);
    chk("freeze_pwm", int'(pwm0), 0);
    en = 1'b1;
    for (int r = 1; r <= 22; r++) begin
      @(negedge clk);
      if (r == 21) chk("resume_duty_21", int'(duty0), 8);
      if (r == 22) chk("resume_duty_22", int'(duty0), 9);
    end

    // into DOWN (period 18, cnt small), start while busy, then async reset
    for (int s = 289; s <= 580; s++) begin
      @(negedge clk);
      start = (s == 300);
    end
    start = 1'b0;
    chk("down_pwm_high", int'(pwm0[0]), 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_pwm",  int'(pwm0),  0);
    chk("arst_busy", int'(busy0), 0);
    chk("arst_duty", int'(duty0), 0);
    chk("arst_ach",  int'(ach0),  0);
    @(negedge clk);
    rst = 1'b0;

    // randomized traffic against the model
    for (int c = 0; c < 20000; c++) begin
      @(negedge clk);
      en    = ($urandom_range(7) != 0);
      start = ($urandom_range(39) == 0);
      stop  = ($urandom_range(2499) == 0);
    end
    en = 1'b1; start = 1'b0; stop = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pwm_fade_sequencer.md
Name: pwm_fade_sequencer

Overview:
- Controller that sequences a shared fade (breathing) pattern across NCH PWM channels, one channel at a time, round-robin.
- Owns the PWM period counter and the duty register of the active channel. Ramps duty up, holds it at maximum, ramps it down, then hands over to the next channel.
- Sits above the single-channel PWM generators. Intended for status-LED banks driven from the same clock.

Parameters:
NCH, 4, number of PWM channels (>=2)
DW, 5, duty register width (must hold MAX_DUTY)
MAX_DUTY, 16, peak duty in clocks-high per period (1..PERIOD)
PERIOD, 32, PWM period in clocks (counter 0..PERIOD-1)
HOLD, 2, number of full periods held at MAX_DUTY (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
en  in  1  clock enable; low freezes all state, counters and outputs
start  in  1  one-cycle request to begin sequencing; ignored while busy
stop  in  1  one-cycle request to stop after the current channel's fade completes
pwm_out  out  NCH  registered PWM outputs; only the active_ch bit may be high
active_ch  out  $clog2(NCH)  index of the channel currently being faded
duty  out  DW  current duty value of the active channel
busy  out  1  high in any state other than IDLE
round_done  out  1  one-cycle pulse when channel NCH-1 finishes its fade

Behaviour:
- Reset is asynchronous, active-high. Reset values:
  - state=IDLE; cnt, duty, hold_cnt, active_ch=0
  - stop_pend=0; pwm_out=0; busy=0; round_done=0
- Reset mid-operation aborts the sequence immediately, with no completion of the fade.
- All registered updates happen only when en=1. start and stop are sampled only when en=1.
- Period counter:
  - cnt runs 0..PERIOD-1 and wraps to 0 in every non-IDLE state.
  - tick = (cnt==PERIOD-1) & en.
  - In IDLE, cnt is held at 0.
- duty, hold_cnt, state and active_ch change only on tick. This keeps every period glitch-free.
- pwm_out[active_ch] <= (cnt < duty); all other bits <= 0. The output lags the compare by 1 clock. In IDLE, pwm_out <= 0.
- States:
  - IDLE: on start, go to UP with cnt=0, duty=0, active_ch=0, stop_pend=0.
  - UP: on tick, duty <= duty+1. If duty==MAX_DUTY-1 at that tick, go to HOLD with hold_cnt=0.
  - HOLD: on tick, hold_cnt <= hold_cnt+1. If hold_cnt==HOLD-1 at that tick, go to DOWN.
  - DOWN: on tick, duty <= duty-1. If duty==1 at that tick (channel done):
    - active_ch <= (active_ch==NCH-1) ? 0 : active_ch+1.
    - round_done pulses if active_ch was NCH-1.
    - If stop_pend or stop is asserted this cycle, go to IDLE and clear stop_pend. Otherwise go to UP with duty=0.
- Fade length per channel: MAX_DUTY + HOLD + MAX_DUTY periods (34 periods = 1088 clocks at defaults).
- stop while busy sets stop_pend, which remains set until honoured. stop in IDLE has no effect.
- start while busy is ignored, including in the same cycle as the stop-honouring transition to IDLE.
- Simultaneous start and stop in IDLE: start wins, and stop is discarded.
- en=0 mid-period: cnt, duty, state and pwm_out all hold their values. The period resumes exactly where it paused.
- Width rules:
  - cnt width = $clog2(PERIOD).
  - hold_cnt width = $clog2(HOLD+1).
  - Duty arithmetic never exceeds MAX_DUTY and never goes below 0; no wrap is possible by construction.

Test Plan:
1. Reset then idle: rst pulse, en=1, no start for 100 clocks -> pwm_out=0, busy=0, duty=0, active_ch=0 throughout.
2. Single fade timing: start at cycle T with defaults -> busy=1 at T+1. pwm_out[0] has 0 high clocks in period 0, 1 in period 1, 16 in periods 16-17 (HOLD). It then ramps down to 1 high clock in period 33. active_ch becomes 1 at T+1+1088.
3. Full round and wrap: let 4 channels run -> round_done pulses exactly once at T+1+4352. active_ch wraps 3->0. Only one pwm_out bit is high at any time.
4. Stop mid-fade: stop pulse during HOLD of channel 2 -> channel 2 completes its DOWN ramp. Then state=IDLE, busy=0, pwm_out=0, active_ch=3. A subsequent start restarts at channel 0.
5. Enable freeze: deassert en for 50 clocks at cnt=10 in UP with duty=8 -> outputs, duty and cnt are unchanged for those 50 clocks. After re-enable, the period completes with the remaining 22 clocks.
6. Edge cases:
   - start while busy has no effect.
   - Async rst asserted mid-DOWN clears all outputs in the same cycle, without waiting for clk.
   - MAX_DUTY=PERIOD=8, HOLD=1 gives 100% duty (pwm_out constantly high) during HOLD.
